hilo_unit: RTL and testbench

//  Downstream stage of the 32-cycle shift-add MULTU multiplier. Tracks the

---
 rtl/hilo_unit.sv | 114 +++++++++++
 tb/tb_hilo_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_unit.sv
// HI/LO register stage for the shift-add MULTU multiplier: iteration tracking, product capture, MFHI/MFLO/MTHI/MTLO.
// Optional HILO_FWD_EN macro: accept MFHI/MFLO in the final RUN cycle and forward the product.
module hilo_unit #(
  parameter int unsigned MUL_CYCLES = 32,
  parameter int unsigned CNT_W      = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue,
  input  logic [5:0]  Signal,
  input  logic [31:0] inputA,
  input  logic [63:0] mulResult,
  output logic [31:0] dataOut,
  output logic        busy,
  output logic        done,
  output logic [31:0] hiOut,
  output logic [31:0] loOut
);

  localparam logic [5:0] F_MFHI  = 6'd16;
  localparam logic [5:0] F_MTHI  = 6'd17;
  localparam logic [5:0] F_MFLO  = 6'd18;
  localparam logic [5:0] F_MTLO  = 6'd19;
  localparam logic [5:0] F_MULTU = 6'd25;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [31:0]      hi_q, hi_n;
  logic [31:0]      lo_q, lo_n;
  logic [31:0]      dout_q, dout_n;
  logic             done_q, done_n;
  logic             last;
  logic             accept;

  assign last = (cnt == CNT_LAST);

`ifdef HILO_FWD_EN
  assign busy = (state == RUN) && !last;
`else
  assign busy = (state == RUN);
`endif

  assign accept  = issue && !busy;
  assign dataOut = dout_q;
  assign done    = done_q;
  assign hiOut   = hi_q;
  assign loOut   = lo_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      dout_q <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      hi_q   <= hi_n;
      lo_q   <= lo_n;
      dout_q <= dout_n;
      done_q <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    hi_n    = hi_q;
    lo_n    = lo_q;
    dout_n  = dout_q;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          case (Signal)
            F_MFHI:  dout_n = hi_q;
            F_MFLO:  dout_n = lo_q;
            F_MTHI:  hi_n   = inputA;
            F_MTLO:  lo_n   = inputA;
            F_MULTU: begin
              state_n = RUN;
              cnt_n   = CNT_W'(1);
            end
            default: ;
          endcase
        end
      end
      RUN: begin
        if (last) begin
          // Capture wins over any MTHI/MTLO accepted in this cycle.
          hi_n    = mulResult[63:32];
          lo_n    = mulResult[31:0];
          state_n = IDLE;
          cnt_n   = '0;
          done_n  = 1'b1;
`ifdef HILO_FWD_EN
          if (accept && Signal == F_MFHI) dout_n = mulResult[63:32];
          if (accept && Signal == F_MFLO) dout_n = mulResult[31:0];
`endif
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_hilo_unit.sv
// Self-checking bench for hilo_unit: vector table, corner sequences and randomized traffic vs a cycle model.
module tb_hilo_unit;

`ifdef HILO_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  localparam logic [5:0] MFHI = 6'd16, MTHI = 6'd17, MFLO = 6'd18, MTLO = 6'd19;
  localparam logic [5:0] MULT = 6'd24, MULTU = 6'd25;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        issue = 1'b0;
  logic [5:0]  sig = '0;
  logic [31:0] in_a = '0;
  logic [63:0] mul_result = '0;
  logic [31:0] dataOut, hiOut, loOut;
  logic        busy, done;

  logic [31:0] op_b = '0;

  int checks = 0;
  int failures = 0;
  int busy_seen = 0;
  int done_seen = 0;

  // Model: multiply tracked as "busy cycles left"; product computed arithmetically.
  int          m_left = 0;
  logic [63:0] m_prod = '0;
  logic [31:0] m_hi = '0, m_lo = '0, m_dout = '0;
  logic        m_done = 1'b0;

  hilo_unit #(.MUL_CYCLES(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .issue(issue), .Signal(sig), .inputA(in_a),
    .mulResult(mul_result), .dataOut(dataOut), .busy(busy), .done(done),
    .hiOut(hiOut), .loOut(loOut)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  s;
    logic [31:0] a, b, hi, lo, dout;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_busy();
    return FWD ? (m_left > 1) : (m_left > 0);
  endfunction

  task automatic model_edge();
    bit acc;
    acc = issue && !exp_busy();
    m_done = 1'b0;
    if (m_left > 0) begin
      if (m_left == 1) begin
        if (acc && sig == MFHI) m_dout = mul_result[63:32];
        if (acc && sig == MFLO) m_dout = mul_result[31:0];
        m_hi = mul_result[63:32];
        m_lo = mul_result[31:0];
        m_done = 1'b1;
      end
      m_left--;
    end else if (acc) begin
      case (sig)
        MFHI:  m_dout = m_hi;
        MFLO:  m_dout = m_lo;
        MTHI:  m_hi = in_a;
        MTLO:  m_lo = in_a;
        MULTU: begin
          m_left = 32;
          m_prod = {32'b0, in_a} * {32'b0, op_b};
        end
        default: ;
      endcase
    end
  endtask

  task automatic compare_all();
    check("busy", busy, exp_busy());
    check("done", done, m_done);
    check("hiOut", hiOut, m_hi);
    check("loOut", loOut, m_lo);
    check("dataOut", dataOut, m_dout);
  endtask

  // Product is only valid in the final cycle before capture; garbage otherwise.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    if (m_left == 1) mul_result = m_prod;
    else mul_result = {$urandom, $urandom};
    if (busy) busy_seen++;
    if (done) done_seen++;
    compare_all();
  endtask

  task automatic mid_reset();
    #3 reset = 1'b1;
    #2;
    m_left = 0; m_hi = '0; m_lo = '0; m_dout = '0; m_done = 1'b0;
    compare_all();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic do_op(input logic [5:0] s, input logic [31:0] a, input logic [31:0] b);
    int n;
    issue = 1'b1; sig = s; in_a = a; op_b = b;
    step();
    issue = 1'b0;
    n = 0;
    while (m_left > 0 && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) check("op_timeout", 1, 0);
  endtask

  initial begin
    logic [31:0] saved;
    int n;

    vecs[0] = '{MULTU, 32'd7, 32'd9, 32'd0, 32'd63, 32'd0};
    vecs[1] = '{MFLO, 32'd0, 32'd0, 32'd0, 32'd63, 32'd63};
    vecs[2] = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 32'd63};
    vecs[3] = '{MFHI, 32'd0, 32'd0, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFE};
    vecs[4] = '{MTHI, 32'h1234, 32'd0, 32'h1234, 32'h1, 32'hFFFFFFFE};
    vecs[5] = '{MTLO, 32'hABCD, 32'd0, 32'h1234, 32'hABCD, 32'hFFFFFFFE};
    vecs[6] = '{MFHI, 32'd0, 32'd0, 32'h1234, 32'hABCD, 32'h1234};
    vecs[7] = '{MFLO, 32'd0, 32'd0, 32'h1234, 32'hABCD, 32'hABCD};
    vecs[8] = '{MULT, 32'd5, 32'd5, 32'h1234, 32'hABCD, 32'hABCD};
    vecs[9] = '{6'd0, 32'hDEAD, 32'd1, 32'h1234, 32'hABCD, 32'hABCD};

    repeat (3) @(posedge clk);
    #1;
    check("rst_hi", hiOut, 0);
    check("rst_lo", loOut, 0);
    check("rst_dout", dataOut, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(negedge clk);
    reset = 1'b0;

    // Busy length and done count for the first multiply.
    busy_seen = 0; done_seen = 0;
    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].s, vecs[i].a, vecs[i].b);
      if (i == 0) begin
        check("busy_cycles", busy_seen, FWD ? 31 : 32);
        check("done_pulses", done_seen, 1);
      end
      check($sformatf("vec%0d_hi", i), hiOut, vecs[i].hi);
      check($sformatf("vec%0d_lo", i), loOut, vecs[i].lo);
      check($sformatf("vec%0d_dout", i), dataOut, vecs[i].dout);
    end

    // MFHI and MULTU issued mid-multiply are ignored.
    issue = 1'b1; sig = MULTU; in_a = 32'd2; op_b = 32'd3;
    step();
    issue = 1'b0;
    repeat (5) step();
    issue = 1'b1; sig = MFHI;
    step();
    check("busy_mfhi_dout", dataOut, 32'hABCD);
    check("busy_mfhi_hi", hiOut, 32'h1234);
    sig = MULTU; in_a = 32'd100; op_b = 32'd100;
    step();
    issue = 1'b0;
    n = 0;
    while (m_left > 0 && n < 100) begin step(); n++; end
    check("busy_multu_lo", loOut, 32'd6);
    check("busy_multu_hi", hiOut, 32'd0);

    // Async reset at cycle 10 of 5x5, then 3x4.
    issue = 1'b1; sig = MULTU; in_a = 32'd5; op_b = 32'd5;
    step();
    issue = 1'b0;
    repeat (9) step();
    done_seen = 0;
    mid_reset();
    check("abort_busy", busy, 0);
    check("abort_lo", loOut, 0);
    repeat (40) step();
    check("abort_no_done", done_seen, 0);
    do_op(MULTU, 32'd3, 32'd4);
    check("after_abort_lo", loOut, 32'd12);

    // MFLO in the final RUN cycle of 6x7.
    issue = 1'b1; sig = MULTU; in_a = 32'd6; op_b = 32'd7;
    step();
    issue = 1'b0;
    n = 0;
    while (m_left > 1 && n < 100) begin step(); n++; end
    check("final_busy", busy, FWD ? 0 : 1);
    saved = dataOut;
    issue = 1'b1; sig = MFLO;
    step();
    issue = 1'b0;
    check("final_mflo_dout", dataOut, FWD ? 32'd42 : saved);
    check("final_lo", loOut, 32'd42);
    check("final_done", done, 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic [5:0] pick[7];
      pick = '{MFHI, MTHI, MFLO, MTLO, MULTU, MULT, 6'd0};
      issue = ($urandom % 3) == 0;
      sig = pick[$urandom % 7];
      if (($urandom % 10) == 0) sig = 6'($urandom);
      in_a = ($urandom % 4 == 0) ? 32'hFFFFFFFF : $urandom;
      op_b = ($urandom % 4 == 0) ? 32'hFFFFFFFF : $urandom;
      step();
      if (($urandom % 200) == 0) mid_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
